// File: rtl/riscv_wb_arbiter_pkg.sv
// Shared writeback configuration: data width, requester count and requester slots.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_wb_arbiter_pkg;

   localparam int WB_NREQ    = 3;
   localparam int WB_IDX_ALU = 0;
   localparam int WB_IDX_LSU = 1;
   localparam int WB_IDX_CSR = 2;

   localparam int REG_ADDR_W = 5;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Generic N-way round-robin arbiter: combinational one-hot grant plus a
// priority pointer that moves just past the last winner.
module riscv_rr_arbiter #(
   parameter int N = 3
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant,
   output logic         o_grant_any
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW:0] N_W = (IW+1)'(N);

   logic [IW-1:0] ptr;
   logic [IW-1:0] grant_idx;
   logic [IW:0]   sum;
   logic [IW-1:0] cand;
   logic [IW:0]   nxt;

   // Walk ptr, ptr+1, ... modulo N; the first requester found wins.
   // Nothing is granted while reset is held.
   always_comb begin
      o_grant     = '0;
      o_grant_any = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      cand        = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (IW+1)'(i);
         if (sum >= N_W) sum = sum - N_W;
         cand = sum[IW-1:0];
         if (!o_grant_any && i_req[cand] && i_rstn) begin
            o_grant[cand] = 1'b1;
            grant_idx     = cand;
            o_grant_any   = 1'b1;
         end
      end
   end

   always_comb begin
      nxt = {1'b0, grant_idx} + (IW+1)'(1);
      if (nxt >= N_W) nxt = '0;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ptr <= '0;
      end else if (o_grant_any) begin
         ptr <= nxt[IW-1:0];
      end
   end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle round-robin, stages its
// write for one cycle into the register file and forwards the staged value.
module riscv_wb_arbiter
   import riscv_wb_arbiter_pkg::*;
#(
   parameter int XLEN = `XLEN,
   parameter int NREQ = WB_NREQ
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [NREQ-1:0]      i_wb_valid,
   input  logic [NREQ*5-1:0]    i_wb_addr,
   input  logic [NREQ*XLEN-1:0] i_wb_data,
   output logic [NREQ-1:0]      o_wb_ready,
   output logic                 o_regfile_rd_wen,
   output logic [4:0]           o_regfile_rd_addr,
   output logic [XLEN-1:0]      o_regfile_rd_data,
   input  logic [4:0]           i_rs1_addr,
   input  logic [4:0]           i_rs2_addr,
   output logic                 o_fwd_rs1_hit,
   output logic                 o_fwd_rs2_hit,
   output logic [XLEN-1:0]      o_fwd_rs1_data,
   output logic [XLEN-1:0]      o_fwd_rs2_data
);

   logic            grant_any;
   reg_addr_t       grant_addr;
   logic [XLEN-1:0] grant_data;

   riscv_rr_arbiter #(.N(NREQ)) u_rr (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_req       (i_wb_valid),
      .o_grant     (o_wb_ready),
      .o_grant_any (grant_any)
   );

   always_comb begin
      grant_addr = '0;
      grant_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (o_wb_ready[k]) begin
            grant_addr = i_wb_addr[5*k +: 5];
            grant_data = i_wb_data[XLEN*k +: XLEN];
         end
      end
   end

   // A grant to x0 is still acknowledged and captured, but never enables a write.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_regfile_rd_wen  <= 1'b0;
         o_regfile_rd_addr <= '0;
         o_regfile_rd_data <= '0;
      end else begin
         o_regfile_rd_wen <= grant_any && (grant_addr != '0);
         if (grant_any) begin
            o_regfile_rd_addr <= grant_addr;
            o_regfile_rd_data <= grant_data;
         end
      end
   end

   assign o_fwd_rs1_hit  = o_regfile_rd_wen && (o_regfile_rd_addr == i_rs1_addr) && (i_rs1_addr != 5'd0);
   assign o_fwd_rs2_hit  = o_regfile_rd_wen && (o_regfile_rd_addr == i_rs2_addr) && (i_rs2_addr != 5'd0);
   assign o_fwd_rs1_data = o_regfile_rd_data;
   assign o_fwd_rs2_data = o_regfile_rd_data;

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width, equal to `XLEN.
REQ-002 SHALL have parameter NREQ, default 3: number of writeback requesters, legal range 2..4.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_wb_valid, input, NREQ bits: per-requester write request.
REQ-006 SHALL have port i_wb_addr, input, NREQ*5 bits: per-requester destination register; requester k uses slice [5k+4:5k].
REQ-007 SHALL have port i_wb_data, input, NREQ*XLEN bits: per-requester write data; requester k uses slice [XLEN*k+XLEN-1:XLEN*k].
REQ-008 SHALL have port o_wb_ready, output, NREQ bits: one-hot grant; the transfer of requester k completes when valid[k] and ready[k] are both high at a clock edge.
REQ-009 SHALL have port o_regfile_rd_wen, output, 1 bit: register-file write enable.
REQ-010 SHALL have port o_regfile_rd_addr, output, 5 bits: register-file write address.
REQ-011 SHALL have port o_regfile_rd_data, output, XLEN bits: register-file write data.
REQ-012 SHALL have ports i_rs1_addr and i_rs2_addr, input, 5 bits each: current read addresses.
REQ-013 SHALL have ports o_fwd_rs1_hit and o_fwd_rs2_hit, output, 1 bit each: the staged write matches the read address.
REQ-014 SHALL have ports o_fwd_rs1_data and o_fwd_rs2_data, output, XLEN bits each: forwarded staged data.

Function
REQ-015 SHALL compute ready combinationally: at most one bit high, and only for a requester whose valid is high.
REQ-016 SHALL arbitrate round-robin.
- A pointer p holds the highest-priority index.
- The search order is p, p+1, ..., wrapping modulo NREQ.
REQ-017 SHALL advance the pointer on a grant to (granted index + 1) mod NREQ; with no grant, the pointer SHALL hold.
REQ-018 SHALL capture the granted addr/data into a one-entry output stage at the clock edge: fixed 1-cycle latency from handshake to o_regfile_rd_*.
REQ-019 SHALL drive o_regfile_rd_wen high for exactly one cycle per accepted request, except when the granted address is 0.
REQ-020 SHALL accept and acknowledge a grant with address 0, but set o_regfile_rd_wen low for it (write dropped).
REQ-021 SHALL set o_regfile_rd_wen low in any cycle following no grant; addr/data SHALL hold their previous values.
REQ-022 SHALL never stall: the output stage drains every cycle, so back-to-back grants are allowed every cycle.
REQ-023 SHALL set o_fwd_rsN_hit = o_regfile_rd_wen && (o_regfile_rd_addr == i_rsN_addr) && (i_rsN_addr != 0); o_fwd_rsN_data SHALL always equal o_regfile_rd_data.
REQ-024 SHALL let requesters that are valid but not granted keep valid, addr and data stable; the arbiter need not check this.
REQ-025 SHALL not depend on the same destination being requested by two requesters: each is written in grant order, and the last grant wins.

Reset
REQ-026 SHALL, on i_rstn low, asynchronously clear:
- the pointer to 0;
- o_regfile_rd_wen to 0;
- o_regfile_rd_addr to 0;
- o_regfile_rd_data to 0.
REQ-027 SHALL hold o_wb_ready and both fwd hits at 0 during reset.
REQ-028 SHALL discard an in-flight staged write if reset asserts mid-operation: no write issues after reset.
REQ-029 SHALL honour valid in the first cycle after reset release, with requester 0 at highest priority.

Structure
REQ-030 SHALL take XLEN from the shared riscv_configs include; NREQ and requester index assignments (0=ALU, 1=LSU, 2=CSR) SHALL be defined in the shared configs.
REQ-031 SHALL use one sub-module, riscv_rr_arbiter: a generic NREQ-way round-robin grant plus pointer, reusable elsewhere.

Verification
REQ-032 SHALL check: after reset, valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2 and a write every cycle, 1 cycle after each grant.
REQ-033 SHALL check: valid=3'b010, addr1=5, data1=0xDEADBEEF -> ready=3'b010 the same cycle; next cycle wen=1, addr=5, data=0xDEADBEEF, then wen=0.
REQ-034 SHALL check: valid=3'b001 with addr0=0 -> ready[0]=1; next cycle wen=0 and the fwd hits are 0 for rs1=0.
REQ-035 SHALL check: staged write addr=7, i_rs1_addr=7, i_rs2_addr=8 -> o_fwd_rs1_hit=1 with the data; o_fwd_rs2_hit=0.
REQ-036 SHALL check: pointer=2, valid=3'b011 -> grant 0, then the pointer becomes 1.
REQ-037 SHALL check: i_rstn low in the cycle after a grant to addr 9 -> wen=0 immediately, no write to x9; pointer=0 after release.
